// File: rtl/eth_tx_pkg.sv
// -----------------------------------------------------------------------------
// eth_tx_pkg
// Shared definitions for the Ethernet frame TX sequencer: the controller state
// encoding, header field widths and default buffer/length widths.
// -----------------------------------------------------------------------------
package eth_tx_pkg;

    localparam int MAC_W      = 48;
    localparam int ETYPE_W    = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_LEN_W  = 9;   // holds 0..256

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/eth_frame_tx_sequencer_if.sv
// -----------------------------------------------------------------------------
// eth_frame_tx_sequencer_if
// Input side of the Ethernet TX core: header handshake plus the byte-wide
// payload AXI stream.
//   master : the sequencer (drives header fields, hdr_valid, payload beat)
//   slave  : the TX core   (drives hdr_ready, tready)
// -----------------------------------------------------------------------------
interface eth_frame_tx_sequencer_if;
    import eth_tx_pkg::*;

    logic               s_eth_hdr_valid;
    logic               s_eth_hdr_ready;
    logic [MAC_W-1:0]   s_eth_dest_mac;
    logic [MAC_W-1:0]   s_eth_src_mac;
    logic [ETYPE_W-1:0] s_eth_type;
    logic [7:0]         s_eth_payload_axis_tdata;
    logic               s_eth_payload_axis_tvalid;
    logic               s_eth_payload_axis_tready;
    logic               s_eth_payload_axis_tlast;
    logic               s_eth_payload_axis_tuser;

    modport master (
        output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        output s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
        output s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
        input  s_eth_hdr_ready, s_eth_payload_axis_tready
    );

    modport slave (
        input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        input  s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
        input  s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
        output s_eth_hdr_ready, s_eth_payload_axis_tready
    );

endinterface

// File: rtl/eth_tx_addr_gen.sv
// -----------------------------------------------------------------------------
// eth_tx_addr_gen
// Frame buffer address / byte counter for the TX sequencer.
//   clk, rst    : clock, synchronous active-low reset
//   load        : command accepted; capture base and len
//   base, len   : first payload byte address, payload byte count
//   active      : sequencer is streaming payload (tvalid high)
//   beat        : payload handshake this cycle (tvalid && tready)
//   buf_raddr   : look-ahead read address for the registered-read buffer
//   last        : current beat is the final byte of the frame
// -----------------------------------------------------------------------------
module eth_tx_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic              active,
    input  logic              beat,
    output logic [ADDR_W-1:0] buf_raddr,
    output logic              last
);

    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              advance;

    assign last    = active && (remaining == LEN_W'(1));
    // The final beat leaves addr and remaining alone, so remaining never
    // drops below 1 and a full 256-byte length fits in LEN_W bits.
    assign advance = beat && !last;

    // The buffer read is registered, so the address for the next beat has to
    // be presented in the same cycle as the current handshake; otherwise a
    // bubble would appear after every accepted byte.
    assign buf_raddr = advance ? addr + ADDR_W'(1) : addr;

    // NOTE: sequential state is always assigned with <=, so every register
    // samples the pre-edge values of its neighbours regardless of order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= base;
            remaining <= len;
        end else if (advance) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
        end
    end

endmodule

// File: rtl/eth_frame_tx_sequencer.sv
// -----------------------------------------------------------------------------
// eth_frame_tx_sequencer
// Moves one Ethernet frame per command from a byte-wide frame buffer into the
// TX core: header handshake first, then the payload at one byte per cycle
// under tready backpressure, tlast on the final byte.
//   clk, rst          : clock, synchronous active-low reset
//   cmd_*             : command handshake (base address, length, header)
//   buf_raddr/rdata   : frame buffer port, rdata = mem[raddr of last cycle]
//   eth_busy          : TX core busy; only blocks command acceptance
//   tx (master)       : header + payload stream towards the TX core
//   frame_done        : one-cycle pulse closing every accepted command
//   frame_err         : pulse with frame_done when the command length was 0
// -----------------------------------------------------------------------------
module eth_frame_tx_sequencer
    import eth_tx_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_base_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAC_W-1:0]    cmd_dest_mac,
    input  logic [MAC_W-1:0]    cmd_src_mac,
    input  logic [ETYPE_W-1:0]  cmd_type,
    output logic [ADDR_W-1:0]   buf_raddr,
    input  logic [7:0]          buf_rdata,
    input  logic                eth_busy,
    eth_frame_tx_sequencer_if.master tx,
    output logic                frame_done,
    output logic                frame_err
);

    state_t state, state_next;
    logic   accept;
    logic   hdr_valid;
    logic   pl_valid;
    logic   last;
    logic   err_q;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        hdr_valid  = 1'b0;
        pl_valid   = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        unique case (state)
            IDLE: begin
                // Held low while in reset so every output reads 0 then.
                cmd_ready = rst && !eth_busy;
                if (cmd_valid && cmd_ready)
                    state_next = (cmd_len == '0) ? DONE : HDR;
            end
            HDR: begin
                hdr_valid = 1'b1;
                if (tx.s_eth_hdr_ready) state_next = STREAM;
            end
            STREAM: begin
                pl_valid = 1'b1;
                if (tx.s_eth_payload_axis_tready && last) state_next = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                frame_err  = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Header fields and the zero-length flag are captured only on accept, so
    // they stay stable for the whole frame whatever the command bus does.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx.s_eth_dest_mac <= '0;
            tx.s_eth_src_mac  <= '0;
            tx.s_eth_type     <= '0;
            err_q             <= 1'b0;
        end else if (accept) begin
            tx.s_eth_dest_mac <= cmd_dest_mac;
            tx.s_eth_src_mac  <= cmd_src_mac;
            tx.s_eth_type     <= cmd_type;
            err_q             <= (cmd_len == '0);
        end
    end

    eth_tx_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .base      (cmd_base_addr),
        .len       (cmd_len),
        .active    (pl_valid),
        .beat      (pl_valid && tx.s_eth_payload_axis_tready),
        .buf_raddr (buf_raddr),
        .last      (last)
    );

    assign tx.s_eth_hdr_valid           = hdr_valid;
    assign tx.s_eth_payload_axis_tvalid = pl_valid;
    // Masked outside STREAM so the data lane reads 0 when idle or in reset.
    assign tx.s_eth_payload_axis_tdata  = pl_valid ? buf_rdata : 8'h00;
    assign tx.s_eth_payload_axis_tlast  = last;
    assign tx.s_eth_payload_axis_tuser  = 1'b0;

endmodule

// File: doc/eth_frame_tx_sequencer.md
# eth_frame_tx_sequencer

Sequences one Ethernet frame at a time from a byte-wide frame buffer into the Ethernet TX core's header and payload AXI-stream interfaces. A command supplies the buffer base address, byte length and header fields. The block then performs the header handshake and streams the payload at one byte per cycle under tready backpressure, asserting tlast on the final byte. It replaces per-byte write functions with a single controller that owns the buffer read port and the TX core's input side.

## Interface

Parameters:

- ADDR_W, 8, frame buffer address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 9, command length width; legal lengths are 0..256.

Ports:

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_base_addr  in  ADDR_W  buffer address of the first payload byte.
- cmd_len  in  LEN_W  payload byte count.
- cmd_dest_mac  in  48  header destination MAC.
- cmd_src_mac  in  48  header source MAC.
- cmd_type  in  16  EtherType.
- buf_raddr  out  ADDR_W  frame buffer read address; the buffer has a registered read.
- buf_rdata  in  8  frame buffer data, equal to mem[buf_raddr of the previous cycle].
- eth_busy  in  1  TX core busy.
- s_eth_hdr_valid  out  1  header valid.
- s_eth_hdr_ready  in  1  header ready.
- s_eth_dest_mac  out  48  registered copy of cmd_dest_mac.
- s_eth_src_mac  out  48  registered copy of cmd_src_mac.
- s_eth_type  out  16  registered copy of cmd_type.
- s_eth_payload_axis_tdata  out  8  payload byte.
- s_eth_payload_axis_tvalid  out  1  payload valid.
- s_eth_payload_axis_tready  in  1  payload ready.
- s_eth_payload_axis_tlast  out  1  final payload byte.
- s_eth_payload_axis_tuser  out  1  tied to 0.
- frame_done  out  1  one-cycle pulse at the end of every accepted command.
- frame_err  out  1  one-cycle pulse coincident with frame_done when cmd_len == 0.

## Operation

States and transitions:

- IDLE:
  - cmd_ready = !eth_busy.
  - On accept, latch the header fields, base address and length.
  - If len == 0, go to DONE with frame_err set; otherwise go to HDR.
- HDR:
  - s_eth_hdr_valid = 1 and buf_raddr = base.
  - On hdr_valid && hdr_ready, go to STREAM.
  - Header fields stay stable while hdr_valid is high.
- STREAM:
  - tvalid = 1 and tdata = buf_rdata.
  - tlast = (remaining == 1).
  - On tvalid && tready: if tlast, go to DONE; else increment addr and decrement remaining.
- DONE:
  - frame_done = 1 and cmd_ready = 0.
  - Go to IDLE next cycle.

Address and count rules:

- buf_raddr is combinational: addr + 1 when a non-last STREAM handshake occurs this cycle, otherwise addr.
- This gives full one-byte-per-cycle throughput with no bubble after stalls.
- Address arithmetic is ADDR_W-bit and wraps: base 0xFE with len 4 reads 0xFE, 0xFF, 0x00, 0x01.
- remaining is LEN_W bits. A 256-byte frame is legal; remaining is never decremented below 1.
- Command inputs are ignored outside the accept cycle.
- Buffer contents must be stable from accept until frame_done. This is a requirement on the producer and is not checked.
- eth_busy gates only command acceptance. It is ignored mid-frame.

## Timing

- Reset (rst == 0 at an edge):
  - Go to IDLE; all outputs 0, including hdr fields, buf_raddr, tvalid, tlast, frame_done and frame_err.
  - Reset mid-frame aborts at that edge: tvalid drops without tlast and no frame_done is issued.
- Accept at cycle T: hdr_valid rises at T+1.
- With hdr_ready and tready held high and length N:
  - Header handshake at T+1.
  - Bytes transfer at T+2 through T+1+N.
  - frame_done at T+2+N.
  - cmd_ready may rise at T+3+N.
- len == 0: frame_done and frame_err at T+1, with no header and no payload.
- Backpressure:
  - tdata and tlast hold while tvalid && !tready.
  - hdr_valid is never withdrawn before its handshake.
- tlast and tvalid never rise in the same cycle as hdr_valid.

## Structure

- Shared package eth_tx_pkg holds:
  - the state enum (IDLE, HDR, STREAM, DONE);
  - MAC_W = 48 and ETYPE_W = 16;
  - default ADDR_W and LEN_W.
- One natural sub-module, eth_tx_addr_gen, holds the addr and remaining counters, the combinational look-ahead buf_raddr and the tlast generation.
- The top level holds the FSM and the header registers.

## Test plan

- 4-byte frame, buffer 0x10..0x13 = A1 B2 C3 D4, base 0x10, all ready high:
  - bytes A1 B2 C3 D4 on consecutive cycles, tlast only with D4;
  - frame_done 6 cycles after accept.
- Same frame with hdr_ready low for 3 cycles and tready toggling 1,0,1,0:
  - header fields stable while hdr_valid is high;
  - byte order unchanged, each byte held across stalls, no duplicates.
- base 0xFE, len 4: reads 0xFE, 0xFF, 0x00, 0x01.
- len 256: exactly 256 beats, tlast on beat 256.
- len 0: frame_done and frame_err at T+1; hdr_valid and tvalid never asserted.
- eth_busy high while a command is offered: cmd_ready stays 0 until eth_busy falls.
- rst low during byte 2 of 4: next cycle all outputs 0 and state IDLE; a new command then runs normally.
